move_checker: RTL

- Parametrised, multi-cycle collision checker for the Tetris datapath.
- One block handles left, right, down and rotate-clockwise requests for all seven pieces in all four rotations. It uses a table-driven 4x4 shape model instead of per-orientation hand-coded terms.
- Sits between the input/gravity controller and the board-update logic.
- Board dimensions are parameters.
- Checks one piece cell per clock, exits early on the first collision, and uses a Start/Done handshake.

---
 rtl/move_checker.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/move_checker.sv
// move_checker: multi-cycle collision checker for left/right/down/rotate requests, one shape cell per clock.
// Define WALL_KICK_EN to retry a failed rotation at x-1 and then at x+1.
module move_checker #(
    parameter int BOARD_W = 16,
    parameter int BOARD_H = 20,
    parameter int CELL_W  = 3,
    parameter int XW      = 4,
    parameter int YW      = 5
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [1:0]        Dir,
    input  logic [2:0]        pieceType,
    input  logic [1:0]        rotation,
    input  logic [XW-1:0]     XPOS,
    input  logic [YW-1:0]     YPOS,
    input  logic [CELL_W-1:0] gameBoard [0:BOARD_H-1][0:BOARD_W-1],
    output logic              Busy,
    output logic              Done,
    output logic              canMove,
    output logic [1:0]        KickDx
);

    typedef enum logic [1:0] {IDLE, CHECK, DONE_S} state_t;

    localparam logic signed [XW+1:0] BOARD_W_S = (XW+2)'(BOARD_W);
    localparam logic signed [YW+1:0] BOARD_H_S = (YW+2)'(BOARD_H);
    localparam logic signed [XW:0]   X_ONE     = (XW+1)'(1);
    localparam logic signed [YW:0]   Y_ONE     = (YW+1)'(1);

    // Spawn offsets packed as {dx[1:0], dy[1:0]}, rows I O T S Z J L, cell order 0..3.
    localparam logic [3:0] SPAWN [0:6][0:3] = '{
        '{4'h1, 4'h5, 4'h9, 4'hD},
        '{4'h4, 4'h8, 4'h5, 4'h9},
        '{4'h4, 4'h1, 4'h5, 4'h9},
        '{4'h4, 4'h8, 4'h1, 4'h5},
        '{4'h0, 4'h4, 4'h5, 4'h9},
        '{4'h0, 4'h1, 4'h5, 4'h9},
        '{4'h8, 4'h1, 4'h5, 4'h9}
    };

    function automatic logic [3:0] cell_off(input logic [2:0] piece,
                                            input logic [1:0] rot,
                                            input logic [1:0] k);
        logic [1:0] dx;
        logic [1:0] dy;
        logic [1:0] tmp;
        logic [1:0] bmax;
        logic [2:0] pidx;
        pidx = (piece == 3'd7) ? 3'd0 : piece;
        {dx, dy} = SPAWN[pidx][k];
        bmax = (pidx == 3'd0) ? 2'd3 : 2'd2;
        // Clockwise step: (dx,dy) -> (B-1-dy, dx); the O piece never turns.
        for (int i = 0; i < 3; i++) begin
            if ((i < int'(rot)) && (pidx != 3'd1)) begin
                tmp = dx;
                dx  = bmax - dy;
                dy  = tmp;
            end
        end
        return {dx, dy};
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           cell_q, cell_d;
    logic [2:0]           piece_q, piece_d;
    logic [1:0]           rot_q, rot_d;
    logic signed [XW:0]   tx_q, tx_d;
    logic signed [YW:0]   ty_q, ty_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 can_move_q, can_move_d;

    logic signed [XW:0]   x_start;
    logic signed [YW:0]   y_start;
    logic [3:0]           offs [0:3];
    logic [3:0]           cur_off;
    logic signed [XW+1:0] cell_x;
    logic signed [YW+1:0] cell_y;
    logic                 in_bounds;
    logic                 cell_blocked;
    logic                 can_kick;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_off
            assign offs[gi] = cell_off(piece_q, rot_q, 2'(gi));
        end
    endgenerate

    assign x_start = $signed({1'b0, XPOS});
    assign y_start = $signed({1'b0, YPOS});
    assign cur_off = offs[cell_q];
    assign cell_x  = $signed({tx_q[XW], tx_q}) + $signed({{XW{1'b0}}, cur_off[3:2]});
    assign cell_y  = $signed({ty_q[YW], ty_q}) + $signed({{YW{1'b0}}, cur_off[1:0]});

    assign in_bounds = !cell_x[XW+1] && (cell_x < BOARD_W_S) &&
                       !cell_y[YW+1] && (cell_y < BOARD_H_S);

    // The board is only read when the cell is in range, so the truncated index is safe.
    assign cell_blocked = !in_bounds || (piece_q == 3'd7) ||
                          (gameBoard[cell_y[YW-1:0]][cell_x[XW-1:0]] != '0);

`ifdef WALL_KICK_EN
    logic [1:0]         dir_q, dir_d;
    logic [XW-1:0]      x_q, x_d;
    logic [1:0]         kick_stage_q, kick_stage_d;
    logic [1:0]         kick_dx_q, kick_dx_d;
    logic signed [XW:0] x_orig;

    assign x_orig   = $signed({1'b0, x_q});
    assign can_kick = (dir_q == 2'b11) && (kick_stage_q != 2'd2) && (piece_q != 3'd7);
    assign KickDx   = kick_dx_q;
`else
    assign can_kick = 1'b0;
    assign KickDx   = 2'b00;
`endif

    always_comb begin
        state_d    = state_q;
        cell_d     = cell_q;
        piece_d    = piece_q;
        rot_d      = rot_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        busy_d     = busy_q;
        done_d     = done_q;
        can_move_d = can_move_q;
`ifdef WALL_KICK_EN
        dir_d        = dir_q;
        x_d          = x_q;
        kick_stage_d = kick_stage_q;
        kick_dx_d    = kick_dx_q;
`endif
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (Start) begin
                    piece_d = pieceType;
                    rot_d   = rotation;
                    tx_d    = x_start;
                    ty_d    = y_start;
                    cell_d  = 2'd0;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                    case (Dir)
                        2'b00:   tx_d  = x_start - X_ONE;
                        2'b01:   tx_d  = x_start + X_ONE;
                        2'b10:   ty_d  = y_start + Y_ONE;
                        default: rot_d = rotation + 2'd1;
                    endcase
`ifdef WALL_KICK_EN
                    dir_d        = Dir;
                    x_d          = XPOS;
                    kick_stage_d = 2'd0;
`endif
                end
            end
            CHECK: begin
                if (cell_blocked) begin
                    if (can_kick) begin
`ifdef WALL_KICK_EN
                        // Stage 1 retries one column left, stage 2 one column right.
                        kick_stage_d = kick_stage_q + 2'd1;
                        tx_d         = (kick_stage_q == 2'd0) ? (x_orig - X_ONE) : (x_orig + X_ONE);
`endif
                        cell_d = 2'd0;
                    end else begin
                        can_move_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = DONE_S;
`ifdef WALL_KICK_EN
                        kick_dx_d  = 2'b00;
`endif
                    end
                end else if (cell_q == 2'd3) begin
                    can_move_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = DONE_S;
`ifdef WALL_KICK_EN
                    case (kick_stage_q)
                        2'd1:    kick_dx_d = 2'b11;
                        2'd2:    kick_dx_d = 2'b01;
                        default: kick_dx_d = 2'b00;
                    endcase
`endif
                end else begin
                    cell_d = cell_q + 2'd1;
                end
            end
            DONE_S: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                cell_d  = 2'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= IDLE;
            cell_q     <= 2'd0;
            piece_q    <= 3'd0;
            rot_q      <= 2'd0;
            tx_q       <= '0;
            ty_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            can_move_q <= 1'b0;
`ifdef WALL_KICK_EN
            dir_q        <= 2'd0;
            x_q          <= '0;
            kick_stage_q <= 2'd0;
            kick_dx_q    <= 2'b00;
`endif
        end else begin
            state_q    <= state_d;
            cell_q     <= cell_d;
            piece_q    <= piece_d;
            rot_q      <= rot_d;
            tx_q       <= tx_d;
            ty_q       <= ty_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            can_move_q <= can_move_d;
`ifdef WALL_KICK_EN
            dir_q        <= dir_d;
            x_q          <= x_d;
            kick_stage_q <= kick_stage_d;
            kick_dx_q    <= kick_dx_d;
`endif
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign canMove = can_move_q;

endmodule
